// File: rtl/operand_fetch_if.sv
// ============================================================================
// Module      : operand_fetch_if
// Description : Decode-side, ALU-side and write-back bundle for operand_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface operand_fetch_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     in_rd;
    logic [AW-1:0]     in_rs;
    logic              in_use_r0;
    logic [1:0]        in_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] r0_rd;
    logic [DATA_W-1:0] rs;
    logic [1:0]        control;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_z;
    logic              z_flag;

    modport slave (
        input  in_valid, in_rd, in_rs, in_use_r0, in_op, out_ready,
        input  wb_en, wb_addr, wb_data, wb_z,
        output in_ready, out_valid, r0_rd, rs, control, z_flag
    );

    modport master (
        output in_valid, in_rd, in_rs, in_use_r0, in_op, out_ready,
        output wb_en, wb_addr, wb_data, wb_z,
        input  in_ready, out_valid, r0_rd, rs, control, z_flag
    );
endinterface

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module      : operand_fetch
// Description : Register file plus one-entry operand latch feeding the ALU.
//               Define OPFETCH_BYPASS_EN for same-cycle write-back forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  wire logic      clk,
    input  wire logic      reset,
    operand_fetch_if.slave bus
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AW:0] c_num_regs = NUM_REGS[AW:0];

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_out_valid;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [1:0]        r_ctrl;
    logic [AW-1:0]     r_a_idx;
    logic [AW-1:0]     r_b_idx;
    logic              r_z;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_hold;
    logic              w_wb_ok;
    logic [AW-1:0]     w_a_idx;
    logic [AW-1:0]     w_b_idx;
    logic [DATA_W-1:0] w_a_val;
    logic [DATA_W-1:0] w_b_val;

    function automatic logic idx_in_range(input logic [AW-1:0] idx);
        return ({1'b0, idx} < c_num_regs);
    endfunction

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_hold     = r_out_valid && !bus.out_ready;
    assign w_wb_ok    = bus.wb_en && idx_in_range(bus.wb_addr);
    assign w_a_idx    = bus.in_use_r0 ? '0 : bus.in_rd;
    assign w_b_idx    = bus.in_rs;

    // Out-of-range indices read as zero; a forwarded write must itself be legal.
    always_comb begin
        w_a_val = '0;
        w_b_val = '0;
        if (idx_in_range(w_a_idx)) w_a_val = r_regs[w_a_idx];
        if (idx_in_range(w_b_idx)) w_b_val = r_regs[w_b_idx];
`ifdef OPFETCH_BYPASS_EN
        if (w_wb_ok && (bus.wb_addr == w_a_idx)) w_a_val = bus.wb_data;
        if (w_wb_ok && (bus.wb_addr == w_b_idx)) w_b_val = bus.wb_data;
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_z <= 1'b0;
        end else if (bus.wb_en) begin
            r_z <= bus.wb_z;
            if (w_wb_ok) r_regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_ctrl      <= '0;
            r_a_idx     <= '0;
            r_b_idx     <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_a         <= w_a_val;
            r_b         <= w_b_val;
            r_ctrl      <= bus.in_op;
            r_a_idx     <= w_a_idx;
            r_b_idx     <= w_b_idx;
        end else if (w_hold) begin
            // Keep a stalled instruction coherent with writes landing behind it.
            if (w_wb_ok && (bus.wb_addr == r_a_idx)) r_a <= bus.wb_data;
            if (w_wb_ok && (bus.wb_addr == r_b_idx)) r_b <= bus.wb_data;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.r0_rd     = r_a;
    assign bus.rs        = r_b;
    assign bus.control   = r_ctrl;
    assign bus.z_flag    = r_z;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module      : tb_operand_fetch
// Description : Directed bench with an expected-transfer queue and monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] c;
    } exp_t;
    exp_t q[$];

    operand_fetch_if #(.DATA_W(8), .NUM_REGS(16)) bus ();

    operand_fetch #(.DATA_W(8), .NUM_REGS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Transfer monitor: every ALU handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL xfer_unexpected: got %h/%h/%h, required none",
                         bus.r0_rd, bus.rs, bus.control);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.r0_rd !== e.a || bus.rs !== e.b || bus.control !== e.c) begin
                    n_fail++;
                    $display("FAIL xfer: got r0_rd=%h rs=%h control=%h, required %h %h %h",
                             bus.r0_rd, bus.rs, bus.control, e.a, e.b, e.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [3:0] addr, input logic [7:0] data, input logic z);
        bus.wb_en = 1'b1; bus.wb_addr = addr; bus.wb_data = data; bus.wb_z = z;
        tick();
        bus.wb_en = 1'b0;
    endtask

    task automatic issue(input logic use_r0, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [1:0] op);
        bus.in_valid = 1'b1; bus.in_use_r0 = use_r0;
        bus.in_rd = rd; bus.in_rs = rs; bus.in_op = op;
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 0; bus.in_rd = 0; bus.in_rs = 0; bus.in_use_r0 = 0; bus.in_op = 0;
        bus.out_ready = 1; bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.wb_z = 0;
        tick(); tick();
        reset = 1'b0;
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_r0_rd",     32'(bus.r0_rd), 0);
        check("reset_rs",        32'(bus.rs), 0);
        check("reset_control",   32'(bus.control), 0);
        check("reset_z_flag",    32'(bus.z_flag), 0);
        check("reset_in_ready",  32'(bus.in_ready), 1);

        // 1: basic read of r3 on both operands
        wb(4'd3, 8'h03, 1'b0);
        check("z_unset_on_wb_z0", 32'(bus.z_flag), 0);
        issue(0, 4'd3, 4'd3, 2'd0);
        q.push_back('{8'h03, 8'h03, 2'd0});
        tick();
        bus.in_valid = 0;
        check("t1_latency_out_valid", 32'(bus.out_valid), 1);
        tick();
        check("t1_drain_out_valid", 32'(bus.out_valid), 0);

        // 2: use_r0 overrides rd
        wb(4'd0, 8'h01, 1'b0);
        wb(4'd2, 8'h00, 1'b0);
        wb(4'd5, 8'h77, 1'b0);
        issue(1, 4'd5, 4'd2, 2'd3);
        q.push_back('{8'h01, 8'h00, 2'd3});
        tick();
        bus.in_valid = 0;
        tick();

        // 3: stall holds outputs and back-pressures the decoder
        bus.out_ready = 0;
        issue(0, 4'd3, 4'd0, 2'd1);
        q.push_back('{8'h03, 8'h01, 2'd1});
        tick();
        issue(0, 4'd5, 4'd3, 2'd2);
        q.push_back('{8'h77, 8'h03, 2'd2});
        for (int i = 0; i < 3; i++) begin
            check("t3_in_ready_stall", 32'(bus.in_ready), 0);
            check("t3_hold_r0_rd",     32'(bus.r0_rd), 32'h03);
            check("t3_hold_rs",        32'(bus.rs), 32'h01);
            check("t3_hold_control",   32'(bus.control), 1);
            tick();
        end
        bus.out_ready = 1;
        tick();
        bus.in_valid = 0;
        check("t3_second_valid", 32'(bus.out_valid), 1);
        tick();

        // 4: write-back refreshes both held operands sourced from r4
        wb(4'd4, 8'h33, 1'b0);
        bus.out_ready = 0;
        issue(0, 4'd4, 4'd4, 2'd2);
        q.push_back('{8'h55, 8'h55, 2'd2});
        tick();
        bus.in_valid = 0;
        check("t4_held_before_wb", 32'(bus.r0_rd), 32'h33);
        wb(4'd4, 8'h55, 1'b0);
        check("t4_refresh_r0_rd", 32'(bus.r0_rd), 32'h55);
        check("t4_refresh_rs",    32'(bus.rs), 32'h55);
        wb(4'd6, 8'h99, 1'b0);
        check("t4_unrelated_r0_rd", 32'(bus.r0_rd), 32'h55);
        check("t4_unrelated_rs",    32'(bus.rs), 32'h55);
        bus.out_ready = 1;
        tick();

        // 5: accept coincident with a write to the source register
        wb(4'd7, 8'h11, 1'b0);
        issue(1, 4'd0, 4'd7, 2'd1);
        bus.wb_en = 1; bus.wb_addr = 4'd7; bus.wb_data = 8'hA0; bus.wb_z = 0;
`ifdef OPFETCH_BYPASS_EN
        q.push_back('{8'h01, 8'hA0, 2'd1});
`else
        q.push_back('{8'h01, 8'h11, 2'd1});
`endif
        tick();
        bus.in_valid = 0; bus.wb_en = 0;
        tick();
        issue(1, 4'd0, 4'd7, 2'd0);
        q.push_back('{8'h01, 8'hA0, 2'd0});
        tick();
        bus.in_valid = 0;
        tick();

        // 6: zero flag, then reset during a stall with a pending write
        wb(4'd8, 8'h00, 1'b1);
        check("t6_z_set", 32'(bus.z_flag), 1);
        tick();
        check("t6_z_sticky", 32'(bus.z_flag), 1);
        bus.out_ready = 0;
        issue(0, 4'd9, 4'd9, 2'd1);
        tick();
        bus.in_valid = 0;
        check("t6_held_valid", 32'(bus.out_valid), 1);
        reset = 1;
        bus.wb_en = 1; bus.wb_addr = 4'd9; bus.wb_data = 8'hEE; bus.wb_z = 1;
        tick();
        reset = 0; bus.wb_en = 0;
        check("t6_reset_out_valid", 32'(bus.out_valid), 0);
        check("t6_reset_z_flag",    32'(bus.z_flag), 0);
        bus.out_ready = 1;
        issue(0, 4'd9, 4'd3, 2'd0);
        q.push_back('{8'h00, 8'h00, 2'd0});
        tick();
        bus.in_valid = 0;
        tick(); tick();

        check("queue_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
